// File: rtl/ftdi_pkg.sv
// Shared FTDI FIFO-bus definitions: FSM state encoding and write timing defaults.
// The receive controller imports this package as well.
package ftdi_pkg;

    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned DEPTH_DEF    = 16;
    localparam int unsigned WR_PULSE_DEF = 2;
    localparam int unsigned CNT_W        = 4;

    typedef logic [BYTE_W-1:0] ftdi_byte_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } ftdi_state_e;

endpackage

// File: rtl/ftdi_tx_ctrl_if.sv
// Host-side byte stream plus FTDI write-side pins of the transmit controller.
interface ftdi_tx_ctrl_if
    import ftdi_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    ftdi_byte_t       din;
    logic             din_valid;
    logic             din_ready;
    logic [LVL_W-1:0] level;
    logic             rd_busy;
    logic             txe;
    logic             wr;
    ftdi_byte_t       dq_out;
    logic             dq_drive;
    logic             busy;

    modport master (
        output din, din_valid, rd_busy, txe,
        input  din_ready, level, wr, dq_out, dq_drive, busy
    );

    modport slave (
        input  din, din_valid, rd_busy, txe,
        output din_ready, level, wr, dq_out, dq_drive, busy
    );

endinterface

// File: rtl/ftdi_tx_fifo.sv
// Single-clock byte FIFO; power-of-two depth so pointers wrap for free.
module ftdi_tx_fifo
    import ftdi_pkg::*;
#(
    parameter  int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LVL_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  ftdi_byte_t       din_i,
    input  logic             pop_i,
    output ftdi_byte_t       head_c_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    ftdi_byte_t       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & ~empty_q;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == LVL_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage carries no reset; only pointer-covered entries are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_c_o = mem_q[rd_ptr_q];
    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign level_o  = count_q;

endmodule

// File: rtl/ftdi_tx_ctrl.sv
// FTDI FIFO-bus transmit controller: byte FIFO feeding a SETUP/STROBE/HOLD write FSM.
// wr and dq_drive are registered straight from next state so the pins never glitch.
module ftdi_tx_ctrl
    import ftdi_pkg::*;
#(
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned WR_PULSE = WR_PULSE_DEF
) (
    input logic           clk,
    input logic           rst,
    ftdi_tx_ctrl_if.slave bus
);

    ftdi_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop;
    ftdi_byte_t       head;
    logic             full, empty;
    logic             wr_q, wr_d;
    logic             drv_q, drv_d;
    logic             busy_q, busy_d;
    ftdi_byte_t       dq_q, dq_d;

    ftdi_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (bus.din_valid),
        .din_i    (bus.din),
        .pop_i    (pop),
        .head_c_o (head),
        .full_o   (full),
        .empty_o  (empty),
        .level_o  (bus.level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // txe/rd_busy only matter in IDLE; a started byte always runs to HOLD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && !bus.txe && !bus.rd_busy) begin
                    state_d = ST_SETUP;
                    pop     = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = '0;
            end
            ST_STROBE: begin
                if (cnt_q == CNT_W'(WR_PULSE - 1)) state_d = ST_HOLD;
                else                               cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_HOLD:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_d   = (state_d != ST_STROBE);
        drv_d  = (state_d != ST_IDLE);
        busy_d = (state_d != ST_IDLE);
        dq_d   = pop ? head : dq_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= 1'b1;
            drv_q  <= 1'b0;
            busy_q <= 1'b0;
            dq_q   <= '0;
        end else begin
            wr_q   <= wr_d;
            drv_q  <= drv_d;
            busy_q <= busy_d;
            dq_q   <= dq_d;
        end
    end

    assign bus.din_ready = ~full;
    assign bus.wr        = wr_q;
    assign bus.dq_drive  = drv_q;
    assign bus.busy      = busy_q;
    assign bus.dq_out    = dq_q;

endmodule
